// File: rtl/toggle_seq_pkg.sv
// Shared definitions for the toggle sequencer.
//   - Default widths and reset period for toggle_seq_ctrl.
//   - Reset value of the optional toggle mask (all ones: every bit toggles).
//   - Sequencer state encoding.
package toggle_seq_pkg;

    localparam int unsigned DEFAULT_WIDTH   = 4;
    localparam int unsigned DEFAULT_CNT_W   = 5;
    localparam int unsigned DEFAULT_BURST_W = 8;
    // Period register value after reset: toggle every 30 cycles.
    localparam int unsigned DEFAULT_PERIOD  = 29;

    // Sliced down to WIDTH by the user.
    localparam logic [31:0] MASK_RST = '1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StHold
    } state_e;

endpackage

// File: rtl/toggle_tick_gen.sv
// Period counter for the toggle sequencer.
// Ports:
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset
//   en     in   count this cycle
//   clr    in   force counter to zero (wins over en)
//   period in   cycles-minus-one between ticks
//   tick   out  high in the counting cycle where the counter has reached period
module toggle_tick_gen
    import toggle_seq_pkg::*;
#(
    parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] period,
    output logic             tick
);

    logic [CNT_W-1:0] cnt;

    assign tick = en && (cnt == period);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/toggle_seq_ctrl.sv
// Programmable toggle sequencer: toggles q every (period+1) RUN cycles, either
// free-running or for a burst of N toggles, with start/pause/stop control.
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   cfg_valid/cfg_ready   config handshake; accepted only in IDLE
//   cfg_period            cycles-minus-one between toggles
//   cfg_burst             toggles per run, 0 = free-run
//   cfg_mask              (TOGGLE_MASK_EN only) bits of q that toggle
//   start, pause, stop    run control; priority stop > pause > start
//   q                     toggled output
//   tick                  high in the cycle whose edge toggles q
//   busy                  state is not IDLE
//   done                  one-cycle pulse after the final burst toggle
// Optional feature macro: TOGGLE_MASK_EN.
module toggle_seq_ctrl
    import toggle_seq_pkg::*;
#(
    parameter int unsigned WIDTH      = DEFAULT_WIDTH,
    parameter int unsigned CNT_W      = DEFAULT_CNT_W,
    parameter int unsigned BURST_W    = DEFAULT_BURST_W,
    parameter int unsigned DEF_PERIOD = DEFAULT_PERIOD
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CNT_W-1:0]   cfg_period,
    input  logic [BURST_W-1:0] cfg_burst,
`ifdef TOGGLE_MASK_EN
    input  logic [WIDTH-1:0]   cfg_mask,
`endif
    input  logic               start,
    input  logic               pause,
    input  logic               stop,
    output logic [WIDTH-1:0]   q,
    output logic               tick,
    output logic               busy,
    output logic               done
);

    state_e             state;
    logic [CNT_W-1:0]   period_r;
    logic [BURST_W-1:0] burst_r;
    logic [BURST_W-1:0] tcount;
    logic [WIDTH-1:0]   toggle_mask;
    logic               run_en;
    logic               cnt_clr;
    logic               last_toggle;

`ifdef TOGGLE_MASK_EN
    logic [WIDTH-1:0]   mask_r;
    assign toggle_mask = mask_r;
`else
    assign toggle_mask = '1;
`endif

    // stop masks the counter so a stop coinciding with a tick suppresses the toggle.
    assign run_en    = (state == StRun) && !stop;
    assign cnt_clr   = (state == StIdle) || stop;
    assign cfg_ready = (state == StIdle);
    assign busy      = (state != StIdle);

    // tcount holds toggles already made, so the one in flight is tcount+1.
    assign last_toggle = tick && (burst_r != '0) && ((tcount + BURST_W'(1)) == burst_r);

    toggle_tick_gen #(
        .CNT_W (CNT_W)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .en     (run_en),
        .clr    (cnt_clr),
        .period (period_r),
        .tick   (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= StIdle;
            tcount   <= '0;
            period_r <= CNT_W'(DEF_PERIOD);
            burst_r  <= '0;
            q        <= '0;
            done     <= 1'b0;
`ifdef TOGGLE_MASK_EN
            mask_r   <= MASK_RST[WIDTH-1:0];
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (cfg_valid) begin
                        period_r <= cfg_period;
                        burst_r  <= cfg_burst;
`ifdef TOGGLE_MASK_EN
                        mask_r   <= cfg_mask;
`endif
                    end
                    if (start && !stop) begin
                        state  <= StRun;
                        tcount <= '0;
                    end
                end
                StRun: begin
                    if (stop) begin
                        state  <= StIdle;
                        tcount <= '0;
                    end else begin
                        if (tick) begin
                            q      <= q ^ toggle_mask;
                            tcount <= tcount + BURST_W'(1);
                        end
                        // A completed burst ends the run even if pause is raised.
                        if (last_toggle) begin
                            state  <= StIdle;
                            tcount <= '0;
                            done   <= 1'b1;
                        end else if (pause) begin
                            state <= StHold;
                        end
                    end
                end
                StHold: begin
                    if (stop) begin
                        state  <= StIdle;
                        tcount <= '0;
                    end else if (!pause) begin
                        state <= StRun;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_toggle_seq_ctrl.sv
// Directed bench for toggle_seq_ctrl. Edge numbers below count rising edges
// after the edge that accepts start (edge 0); samples are taken 1 ns after an edge.
module tb_toggle_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [4:0] cfg_period;
    logic [7:0] cfg_burst;
`ifdef TOGGLE_MASK_EN
    logic [3:0] cfg_mask;
`endif
    logic       start;
    logic       pause;
    logic       stop;
    logic [3:0] q;
    logic       tick;
    logic       busy;
    logic       done;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    toggle_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_period (cfg_period),
        .cfg_burst  (cfg_burst),
`ifdef TOGGLE_MASK_EN
        .cfg_mask   (cfg_mask),
`endif
        .start      (start),
        .pause      (pause),
        .stop       (stop),
        .q          (q),
        .tick       (tick),
        .busy       (busy),
        .done       (done)
    );

    task automatic go(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst        = 1'b1;
        cfg_valid  = 1'b0;
        cfg_period = '0;
        cfg_burst  = '0;
`ifdef TOGGLE_MASK_EN
        cfg_mask   = 4'hF;
`endif
        start      = 1'b0;
        pause      = 1'b0;
        stop       = 1'b0;

        // Reset state
        go(2);
        check("rst_q", q, 0);
        check("rst_tick", tick, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cfg_ready", cfg_ready, 1);
        rst = 1'b0;

        // Default period: toggles at edges 30 and 60
        start = 1'b1; go(1); start = 1'b0;
        check("def_busy", busy, 1);
        go(28);
        check("def_e28_tick", tick, 0);
        check("def_e28_q", q, 0);
        go(1);
        check("def_e29_tick", tick, 1);
        check("def_e29_q", q, 0);
        go(1);
        check("def_e30_q", q, 4'hF);
        check("def_e30_tick", tick, 0);
        go(29);
        check("def_e59_tick", tick, 1);
        go(1);
        check("def_e60_q", q, 0);
        stop = 1'b1; go(1); stop = 1'b0;
        check("def_stop_busy", busy, 0);
        check("def_stop_done", done, 0);

        // Burst of 3 at period 4, config offered together with start
        cfg_valid = 1'b1; cfg_period = 5'd4; cfg_burst = 8'd3; start = 1'b1;
        go(1);
        cfg_valid = 1'b0; start = 1'b0;
        go(4);
        check("burst_e4_tick", tick, 1);
        go(1);
        check("burst_e5_q", q, 4'hF);
        go(5);
        check("burst_e10_q", q, 0);
        go(4);
        check("burst_e14_busy", busy, 1);
        check("burst_e14_done", done, 0);
        go(1);
        check("burst_e15_q", q, 4'hF);
        check("burst_e15_done", done, 1);
        check("burst_e15_busy", busy, 0);
        go(1);
        check("burst_e16_done", done, 0);

        // Pause of 10 cycles from edge 12 pushes the first toggle to edge 40
        cfg_valid = 1'b1; cfg_period = 5'd29; cfg_burst = 8'd0; start = 1'b1;
        go(1);
        cfg_valid = 1'b0; start = 1'b0;
        go(11);
        pause = 1'b1;
        go(1);
        check("pause_busy", busy, 1);
        go(9);
        check("pause_hold_q", q, 4'hF);
        check("pause_hold_tick", tick, 0);
        pause = 1'b0;
        go(18);
        check("pause_e39_tick", tick, 1);
        check("pause_e39_q", q, 4'hF);
        go(1);
        check("pause_e40_q", q, 0);
        stop = 1'b1; go(1); stop = 1'b0;

        // Stop at edge 20, restart at edge 25, next toggle at edge 55
        start = 1'b1; go(1); start = 1'b0;
        go(19);
        stop = 1'b1; go(1); stop = 1'b0;
        check("stop_busy", busy, 0);
        check("stop_done", done, 0);
        check("stop_q", q, 0);
        go(4);
        start = 1'b1; go(1); start = 1'b0;
        check("restart_busy", busy, 1);
        go(29);
        check("restart_e54_tick", tick, 1);
        check("restart_e54_q", q, 0);
        go(1);
        check("restart_e55_q", q, 4'hF);
        stop = 1'b1; go(1); stop = 1'b0;
        check("stop2_q_kept", q, 4'hF);
        check("stop2_done", done, 0);

        // Stop coinciding with the final burst toggle
        cfg_valid = 1'b1; cfg_period = 5'd1; cfg_burst = 8'd1; start = 1'b1;
        go(1);
        cfg_valid = 1'b0; start = 1'b0;
        go(1);
        check("sf_tick_pre", tick, 1);
        stop = 1'b1; #1;
        check("sf_tick_masked", tick, 0);
        go(1);
        stop = 1'b0;
        check("sf_q", q, 4'hF);
        check("sf_busy", busy, 0);
        check("sf_done", done, 0);
        go(1);
        check("sf_done_late", done, 0);

        // Config ignored while busy, then reset mid-run at edge 17
        cfg_valid = 1'b1; cfg_period = 5'd29; cfg_burst = 8'd0; start = 1'b1;
        go(1);
        cfg_valid = 1'b0; start = 1'b0;
        go(3);
        cfg_valid = 1'b1; cfg_period = 5'd4; #1;
        check("busy_cfg_ready", cfg_ready, 0);
        go(1);
        cfg_valid = 1'b0;
        go(12);
        check("busy_cfg_q_e16", q, 4'hF);
        rst = 1'b1; go(1); rst = 1'b0;
        check("midrst_q", q, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_cfg_ready", cfg_ready, 1);
        go(1);
        check("midrst_done_late", done, 0);
        start = 1'b1; go(1); start = 1'b0;
        go(29);
        check("midrst_def_period_tick", tick, 1);
        stop = 1'b1; go(1); stop = 1'b0;

`ifdef TOGGLE_MASK_EN
        // Mask 0101 at period 2
        cfg_valid = 1'b1; cfg_period = 5'd2; cfg_burst = 8'd0; cfg_mask = 4'b0101;
        start = 1'b1;
        go(1);
        cfg_valid = 1'b0; start = 1'b0;
        go(3);
        check("mask_e3_q", q, 4'b0101);
        go(3);
        check("mask_e6_q", q, 4'b0000);
        stop = 1'b1; go(1); stop = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/toggle_seq_ctrl.md
# toggle_seq_ctrl

Programmable sequencer for the 4-bit periodic toggle register. It replaces the hard-wired 30-cycle toggle with a configurable period and an optional burst length of N toggles. It adds start, pause and stop control and reports busy/tick/done status. It sits between a host or config register bank and the toggled output `q`.

## Interface
- `WIDTH`, 4, width of toggled output `q`
- `CNT_W`, 5, cycle-counter width; max period value 2^CNT_W-1
- `BURST_W`, 8, burst-length width
- `DEF_PERIOD`, 29, period value after reset (toggle every 30 cycles)
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `cfg_valid`  in  1  config offer
- `cfg_ready`  out  1  config accepted when high with `cfg_valid`
- `cfg_period`  in  CNT_W  cycles-minus-one between toggles
- `cfg_burst`  in  BURST_W  toggles per run; 0 = free-run
- `start`  in  1  begin run (IDLE only)
- `pause`  in  1  level; freeze while high
- `stop`  in  1  abort run, return to IDLE
- `q`  out  WIDTH  toggled output
- `tick`  out  1  high in cycle whose edge toggles `q`
- `busy`  out  1  state != IDLE
- `done`  out  1  one-cycle pulse after final burst toggle

## Operation
- States: IDLE, RUN, HOLD.
- Input priority: `stop` > `pause` > `start`.
- IDLE:
  - `cfg_ready`=1.
  - `cfg_valid` latches `period_r`/`burst_r`.
  - `start` → RUN with `cnt`=0 and `tcount`=0.
  - `cfg_valid` and `start` in the same cycle: the new config applies to this run.
- RUN:
  - `cnt`++ each cycle.
  - When `cnt`==`period_r`: `tick`=1 (combinational), and that edge sets `q`<=~`q`, `cnt`<=0, `tcount`++.
  - If `burst_r`!=0 and the toggle is number `burst_r`: → IDLE, registered `done`=1 the next cycle.
- HOLD:
  - Entered from RUN while `pause`=1; exits to RUN when `pause`=0.
  - `cnt`, `tcount` and `q` frozen; `tick`=0.
- `stop` in RUN or HOLD: → IDLE next edge, `cnt`/`tcount` cleared, `q` retains its value, no `done`.
- `start` outside IDLE is ignored.
- `cfg_valid` outside IDLE is ignored (`cfg_ready`=0); a config is never lost silently.
- `period_r`=0: toggle on every RUN cycle.
- `tcount` is BURST_W bits; in free-run mode it wraps silently with no effect.
- `stop` and a final toggle in the same cycle: `stop` wins, so `q` is not toggled and `done` is not asserted.

## Timing
- Reset values:
  - outputs: `q`=0, `tick`=0, `busy`=0, `done`=0, `cfg_ready`=1
  - internal: state IDLE, `cnt`=0, `tcount`=0, `period_r`=DEF_PERIOD, `burst_r`=0
- Reset mid-run aborts immediately, with no `done`.
- First toggle happens at the (`period_r`+1)-th rising edge after the `start` edge; later toggles every `period_r`+1 edges of RUN.
- A pause of P cycles delays all subsequent toggles by exactly P cycles.
- `done` is asserted one cycle after the final toggle edge, coincident with `busy`=0; a new `start` is legal in that cycle.
- `busy` rises the cycle after `start` is accepted.

## Configuration
- `TOGGLE_MASK_EN`:
  - When defined, adds port `cfg_mask` (in, WIDTH), latched with the config; reset value all ones. A toggle becomes `q`<=`q`^`mask_r`.
  - When undefined, there is no port and all bits toggle.

## Structure
- Package `toggle_seq_pkg` holds:
  - the state enum (IDLE/RUN/HOLD)
  - `DEF_PERIOD` and default widths
  - the mask reset constant
- Sub-module `toggle_tick_gen` holds the period counter: inputs `en`, `clr`, `period`; output `tick`.
- The top holds the FSM, config registers, `tcount` and `q`.

## Test plan
- **Default period:** reset, then `start` → `q` 0→F at edge 30 after start, F→0 at edge 60; `tick` one cycle before each edge.
- **Burst:** cfg period=4, burst=3, then `start` → toggles at edges 5/10/15, final `q`=F, `done` pulse at cycle 16, `busy`=0.
- **Pause:** default period; `pause` held 10 cycles starting at cycle 12 → first toggle at edge 40, `q` unchanged during HOLD.
- **Stop:** `stop` at cycle 20, then `start` at 25 → no `done`, `q` keeps its value, next toggle at edge 55 (count restarted).
- **Config while busy and reset mid-run:** `cfg_valid` in RUN → `cfg_ready`=0 and period unchanged. `rst` at cycle 17 → `q`=0, IDLE, no `done`.
- **Mask (`TOGGLE_MASK_EN`):** mask=0101, period=2 → `q` 0000→0101→0000 every 3 cycles.
